// File: rtl/apb_pkg.sv
// apb_pkg: shared APB types, constants and the region-to-PPROT map used by requester and completer.
package apb_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP_ERR} completer_state_t;
  localparam int APB_WORD_BYTES = 4;
  // Each 32-byte region demands the PPROT attributes encoded in address bits [7:5].
  function automatic logic [2:0] getPprot(input logic [31:0] addr);
    return addr[7:5];
  endfunction
  function automatic logic [31:0] getAddrforPprot(input logic [2:0] prot);
    return {24'h0, prot, 5'h0};
  endfunction
endpackage

// File: rtl/apb_mem_completer_ram.sv
// apb_mem_completer_ram: word memory, byte-enabled write port with async clear, combinational read port.
module apb_mem_completer_ram #(
  parameter int DEPTH = 64,
  parameter int DW    = 32,
  parameter int IW    = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_we,
  input  logic [IW-1:0]   i_waddr,
  input  logic [DW/8-1:0] i_wstrb,
  input  logic [DW-1:0]   i_wdata,
  input  logic [IW-1:0]   i_raddr,
  output logic [DW-1:0]   o_rdata
);
  logic [DW-1:0] r_mem [DEPTH];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_mem <= '{default: '0};
    else if (i_we)
      for (int b = 0; b < DW/8; b++)
        if (i_wstrb[b]) r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/apb_mem_completer.sv
// apb_mem_completer: APB4 word-memory completer with wait states, byte strobes and error response.
// Optional region protection check enabled by APB_MEM_COMPLETER_PROT_CHECK_EN.
module apb_mem_completer
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int STRB_WIDTH  = DATA_WIDTH/8,
  parameter int MEM_DEPTH   = 64,
  parameter int WAIT_STATES = 0
) (
  input  logic                  pclk,
  input  logic                  presetn,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [2:0]            pprot,
  input  logic [DATA_WIDTH-1:0] pwdata,
  input  logic [STRB_WIDTH-1:0] pstrb,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pready,
  output logic                  pslverr
);
  localparam int IW  = $clog2(MEM_DEPTH);
  localparam int OFF = $clog2(APB_WORD_BYTES);
  completer_state_t r_state, w_state_nxt;
  logic [3:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr;
  logic [DATA_WIDTH-1:0] r_wdata, r_prdata, w_prdata_nxt, w_ram_rdata, w_rdata;
  logic [STRB_WIDTH-1:0] r_strb;
  logic [2:0] r_prot, w_prot;
  logic [IW-1:0] w_idx;
  logic r_write, r_pready, r_pslverr, w_pready_nxt, w_pslverr_nxt, w_write, w_err, w_prot_err, w_we;
  // While idle the setup-phase bus is decoded directly so a zero-wait response is ready at the setup edge.
  assign w_addr  = (r_state == IDLE) ? paddr  : r_addr;
  assign w_prot  = (r_state == IDLE) ? pprot  : r_prot;
  assign w_write = (r_state == IDLE) ? pwrite : r_write;
  assign w_idx   = w_addr[OFF +: IW];
`ifdef APB_MEM_COMPLETER_PROT_CHECK_EN
  assign w_prot_err = |(getPprot(32'(w_addr)) & ~w_prot);
`else
  logic w_unused_prot;
  assign w_unused_prot = ^w_prot;
  assign w_prot_err    = 1'b0;
`endif
  assign w_err = (|w_addr[OFF-1:0]) | ({1'b0, w_idx} >= (IW+1)'(MEM_DEPTH))
               | ((w_addr >> (OFF+IW)) != '0) | w_prot_err;
  assign w_rdata   = (w_err || w_write) ? '0 : w_ram_rdata;
  assign w_cnt_inc = r_cnt + 4'd1;
  assign w_we      = (r_state == ACCESS) && r_pready && r_write && !r_pslverr;
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_pready_nxt  = 1'b0;
    w_pslverr_nxt = 1'b0;
    w_prdata_nxt  = '0;
    case (r_state)
      IDLE:
        if (psel && !penable) begin
          w_state_nxt = ACCESS;
          w_cnt_nxt   = '0;
          if (WAIT_STATES == 0) begin
            w_pready_nxt  = 1'b1;
            w_pslverr_nxt = w_err;
            w_prdata_nxt  = w_rdata;
          end
        end
      ACCESS:
        if (r_pready) w_state_nxt = IDLE;
        else if (!psel) begin
          w_state_nxt   = RESP_ERR;
          w_pready_nxt  = 1'b1;
          w_pslverr_nxt = 1'b1;
        end else begin
          w_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc == 4'(WAIT_STATES)) begin
            w_pready_nxt  = 1'b1;
            w_pslverr_nxt = w_err;
            w_prdata_nxt  = w_rdata;
          end
        end
      default: w_state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge pclk or negedge presetn)
    if (!presetn) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      r_prdata  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_pready  <= w_pready_nxt;
      r_pslverr <= w_pslverr_nxt;
      r_prdata  <= w_prdata_nxt;
    end
  always_ff @(posedge pclk or negedge presetn)
    if (!presetn) begin
      r_addr  <= '0;
      r_write <= 1'b0;
      r_prot  <= '0;
      r_wdata <= '0;
      r_strb  <= '0;
    end else if (r_state == IDLE && psel && !penable) begin
      r_addr  <= paddr;
      r_write <= pwrite;
      r_prot  <= pprot;
      r_wdata <= pwdata;
      r_strb  <= pstrb;
    end
  apb_mem_completer_ram #(.DEPTH(MEM_DEPTH), .DW(DATA_WIDTH), .IW(IW)) u_ram (
    .clk     (pclk),
    .rst_n   (presetn),
    .i_we    (w_we),
    .i_waddr (r_addr[OFF +: IW]),
    .i_wstrb (r_strb),
    .i_wdata (r_wdata),
    .i_raddr (w_idx),
    .o_rdata (w_ram_rdata)
  );
  assign prdata  = r_prdata;
  assign pready  = r_pready;
  assign pslverr = r_pslverr;
endmodule

// File: tb/tb_apb_mem_completer.sv
// tb_apb_mem_completer: scoreboard bench driving a zero-wait and a three-wait completer over one shared bus.
module tb_apb_mem_completer;
  import apb_pkg::*;
`ifdef APB_MEM_COMPLETER_PROT_CHECK_EN
  localparam logic PROT_ERR = 1'b1;
`else
  localparam logic PROT_ERR = 1'b0;
`endif
  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          waitc;
    string       name;
  } exp_t;

  logic clk = 1'b0, rst_n = 1'b0, use3 = 1'b0;
  logic psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [31:0] paddr = '0, pwdata = '0;
  logic [2:0] pprot = '0;
  logic [3:0] pstrb = '0;
  logic psel0, psel3, pready0, pready3, pslverr0, pslverr3;
  logic [31:0] prdata0, prdata3;
  logic m_rdy, m_err, prev_rdy = 1'b0;
  logic [31:0] m_rdata;
  exp_t sb[$];
  int checks = 0, errors = 0, wcnt = 0;

  always #5 clk = ~clk;
  assign psel0   = psel & ~use3;
  assign psel3   = psel & use3;
  assign m_rdy   = use3 ? pready3 : pready0;
  assign m_err   = use3 ? pslverr3 : pslverr0;
  assign m_rdata = use3 ? prdata3 : prdata0;

  apb_mem_completer #(.WAIT_STATES(0)) dut0 (
    .pclk(clk), .presetn(rst_n), .psel(psel0), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pprot(pprot), .pwdata(pwdata), .pstrb(pstrb),
    .prdata(prdata0), .pready(pready0), .pslverr(pslverr0));
  apb_mem_completer #(.WAIT_STATES(3)) dut3 (
    .pclk(clk), .presetn(rst_n), .psel(psel3), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pprot(pprot), .pwdata(pwdata), .pstrb(pstrb),
    .prdata(prdata3), .pready(pready3), .pslverr(pslverr3));

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (m_rdy) begin
      chk("pready_single_cycle", 32'(prev_rdy), 32'd0);
      if (sb.size() == 0) chk("unexpected_response", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, "_prdata"}, m_rdata, e.rdata);
        chk({e.name, "_pslverr"}, 32'(m_err), 32'(e.err));
        if (e.waitc >= 0) chk({e.name, "_waits"}, 32'(wcnt), 32'(e.waitc));
      end
      wcnt = 0;
    end else begin
      if (prev_rdy) chk("prdata_zero_after_pready", m_rdata, 32'd0);
      if (!penable) wcnt = 0;
      else if (psel && rst_n) wcnt++;
    end
    prev_rdy = m_rdy;
  end

  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      input logic [2:0] p, input logic [31:0] er, input logic ee, input int ew,
                      input string n);
    int i;
    sb.push_back('{er, ee, ew, n});
    psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d; pstrb = s; pprot = p;
    @(posedge clk); #1;
    penable = 1'b1;
    i = 0;
    while (!m_rdy && i < 20) begin
      @(posedge clk); #1;
      i++;
    end
    if (!m_rdy) chk({n, "_timeout"}, 32'd0, 32'd1);
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] er, input logic ee, input int ew, input string n);
    xfer(1'b0, a, 32'h0, 4'h0, getPprot(a), er, ee, ew, n);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic ee,
                    input int ew, input string n);
    xfer(1'b1, a, d, s, getPprot(a), 32'h0, ee, ew, n);
  endtask

  initial begin
    int i;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pready0", 32'(pready0), 32'd0);
    chk("rst_pslverr0", 32'(pslverr0), 32'd0);
    chk("rst_prdata0", prdata0, 32'd0);
    chk("rst_pready3", 32'(pready3), 32'd0);
    chk("rst_prdata3", prdata3, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    rd(32'h4, 32'h0, 1'b0, 0, "rd4_init");
    wr(32'h4, 32'hFFFF_FFFF, 4'hF, 1'b0, 0, "wr4_full");
    rd(32'h4, 32'hFFFF_FFFF, 1'b0, 0, "rd4_full");
    wr(32'h84, 32'hFFFF_FFFF, 4'h1, 1'b0, 0, "wr84_strb1");
    rd(32'h84, 32'h0000_00FF, 1'b0, 0, "rd84_strb1");
    rd(32'h3, 32'h0, 1'b1, 0, "rd_unaligned");
    wr(32'h100, 32'hFFFF_FFFF, 4'hF, 1'b1, 0, "wr_out_of_range");
    rd(32'h0, 32'h0, 1'b0, 0, "rd0_unchanged");
    wr(32'h4, 32'h0, 4'h0, 1'b0, 0, "wr4_strb0");
    rd(32'h4, 32'hFFFF_FFFF, 1'b0, 0, "rd4_after_strb0");
    wr(32'h8, 32'h1234_5678, 4'b0110, 1'b0, 0, "wr8_strb6");
    rd(32'h8, 32'h0034_5600, 1'b0, 0, "rd8_strb6");
    xfer(1'b0, getAddrforPprot(3'b111), 32'h0, 4'h0, 3'b111, 32'h0, 1'b0, 0, "prot_111");
    xfer(1'b0, getAddrforPprot(3'b111), 32'h0, 4'h0, 3'b110, 32'h0, PROT_ERR, 0, "prot_110");
    xfer(1'b0, getAddrforPprot(3'b111), 32'h0, 4'h0, 3'b101, 32'h0, PROT_ERR, 0, "prot_101");
    xfer(1'b0, getAddrforPprot(3'b111), 32'h0, 4'h0, 3'b011, 32'h0, PROT_ERR, 0, "prot_011");
    // penable without a setup phase must not produce a response
    psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 32'h4;
    i = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (pready0) i++;
    end
    psel = 1'b0; penable = 1'b0;
    chk("penable_without_setup", 32'(i), 32'd0);
    @(posedge clk); #1;
    use3 = 1'b1;
    rd(32'h4, 32'h0, 1'b0, 3, "ws3_rd4");
    wr(32'hC, 32'hA5A5_A5A5, 4'hF, 1'b0, 3, "ws3_wrC");
    rd(32'hC, 32'hA5A5_A5A5, 1'b0, 3, "ws3_rdC");
    sb.push_back('{32'h0, 1'b1, -1, "psel_drop"});
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'hC; pwdata = 32'h0; pstrb = 4'hF; pprot = 3'b000;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    chk("psel_drop_pready_next_cycle", 32'(pready3), 32'd1);
    @(posedge clk); #1;
    rd(32'hC, 32'hA5A5_A5A5, 1'b0, 3, "ws3_rdC_after_drop");
    use3 = 1'b0;
    @(posedge clk); #1;
    // reset asserted while a zero-wait write is presenting pready
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h10; pwdata = 32'hDEAD_BEEF; pstrb = 4'hF; pprot = 3'b000;
    @(posedge clk); #1;
    penable = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("midreset_pready", 32'(pready0), 32'd0);
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    rd(32'h10, 32'h0, 1'b0, 0, "rd10_after_reset");
    rd(32'h4, 32'h0, 1'b0, 0, "rd4_cleared");
    repeat (2) @(posedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
